// File: rtl/harvard_mem_sys.sv
// Memory subsystem for the Harvard micro: loadable instruction memory, data RAM and an I/O window,
// fronted by a HALT/LOAD/RUN controller that gates the core and a req/ack data port.
module harvard_mem_sys #(
    parameter int                   DATA_W  = 8,
    parameter int                   INSTR_W = 9,
    parameter int                   IADDR_W = 8,
    parameter int                   DADDR_W = 8,
    parameter int                   RD_WAIT = 0,
    parameter logic [DADDR_W-1:0]   IO_BASE = 8'hF0,
    parameter int                   N_IO    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [IADDR_W-1:0]       i_Address_Instruction,
    output logic [INSTR_W-1:0]       o_Instruction,
    output logic                     o_Instr_Valid,
    input  logic [DADDR_W-1:0]       i_Address_Data,
    input  logic [DATA_W-1:0]        i_DataIn,
    input  logic                     i_WR,
    input  logic                     i_Req,
    output logic                     o_Ready,
    output logic                     o_Ack,
    output logic [DATA_W-1:0]        o_DataOut,
    input  logic                     i_Load_En,
    input  logic [INSTR_W-1:0]       i_Load_Data,
    input  logic                     i_Load_Valid,
    output logic                     o_Load_Ready,
    output logic                     o_Load_Done,
    output logic                     o_Core_Run,
    input  logic [N_IO*DATA_W-1:0]   i_IO_In,
    output logic [N_IO*DATA_W-1:0]   o_IO_Out
);

    localparam int                 IOI_W  = (N_IO > 1) ? $clog2(N_IO) : 1;
    localparam logic [DADDR_W:0]   IO_END = {1'b0, IO_BASE} + (DADDR_W+1)'(N_IO);

    typedef enum logic [1:0] {S_HALT, S_LOAD, S_RUN} state_t;

    state_t                         state, state_nx;
    logic [IADDR_W-1:0]             ptr;
    logic                           load_fire, load_last;
    logic                           done_q, ivld_q;
    logic                           busy, rd_pend, ack_q;
    logic [3:0]                     cnt;
    logic [DADDR_W-1:0]             addr_q, rd_addr;
    logic                           accept, abort, wr_fire;
    logic                           w_ram, w_io, r_ram, r_io;
    logic [IOI_W-1:0]               w_idx, r_idx;
    logic [DATA_W-1:0]              rdata;
    logic [N_IO-1:0][DATA_W-1:0]    io_in_a, io_q;

    logic [INSTR_W-1:0]             imem [2**IADDR_W];
    logic [DATA_W-1:0]              ram  [2**DADDR_W];

    // ---------------- control FSM ----------------
    assign load_fire = (state == S_LOAD) && i_Load_Valid;
    assign load_last = load_fire && (ptr == {IADDR_W{1'b1}});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_HALT;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_HALT:  state_nx = i_Load_En ? S_LOAD : S_RUN;
            S_LOAD:  if (!i_Load_En || load_last) state_nx = S_RUN;
            S_RUN:   if (i_Load_En) state_nx = S_LOAD;
            default: state_nx = S_HALT;
        endcase
    end

    assign o_Core_Run    = (state == S_RUN);
    assign o_Load_Ready  = (state == S_LOAD);
    assign o_Load_Done   = done_q;
    assign o_Ready       = (state == S_RUN) && !busy;
    assign o_Ack         = ack_q;
    assign o_Instr_Valid = ivld_q && (state == S_RUN);
    assign o_IO_Out      = io_q;
    assign io_in_a       = i_IO_In;

    // ---------------- loader / instruction memory ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == S_LOAD) && (state_nx == S_RUN);
            if (state != S_LOAD && state_nx == S_LOAD) ptr <= '0;
            else if (load_fire)                       ptr <= ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load_fire) imem[ptr] <= i_Load_Data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_Instruction <= '0;
            ivld_q        <= 1'b0;
        end else begin
            ivld_q <= (state == S_RUN);
            if (state == S_RUN) o_Instruction <= imem[i_Address_Instruction];
        end
    end

    // ---------------- data port ----------------
    // A request arriving in the same cycle the loader takes over is not accepted,
    // so a write is never committed without its ack.
    assign accept  = i_Req && o_Ready && !i_Load_En;
    assign abort   = (state == S_RUN) && i_Load_En;
    assign wr_fire = accept && i_WR;
    assign rd_addr = rd_pend ? addr_q : i_Address_Data;

    always_comb begin
        w_ram = i_Address_Data < IO_BASE;
        w_io  = !w_ram && ({1'b0, i_Address_Data} < IO_END);
        w_idx = IOI_W'(i_Address_Data - IO_BASE);
        r_ram = rd_addr < IO_BASE;
        r_io  = !r_ram && ({1'b0, rd_addr} < IO_END);
        r_idx = IOI_W'(rd_addr - IO_BASE);
        rdata = '0;
        if (r_ram)     rdata = ram[rd_addr];
        else if (r_io) rdata = io_in_a[r_idx];
    end

    always_ff @(posedge clk) begin
        if (wr_fire && w_ram) ram[i_Address_Data] <= i_DataIn;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy      <= 1'b0;
            rd_pend   <= 1'b0;
            ack_q     <= 1'b0;
            cnt       <= '0;
            addr_q    <= '0;
            o_DataOut <= '0;
            io_q      <= '0;
        end else begin
            ack_q <= 1'b0;
            if (wr_fire && w_io) io_q[w_idx] <= i_DataIn;
            if (abort || state != S_RUN) begin
                busy    <= 1'b0;
                rd_pend <= 1'b0;
            end else if (accept) begin
                busy   <= 1'b1;
                addr_q <= i_Address_Data;
                if (i_WR) begin
                    ack_q <= 1'b1;
                end else if (RD_WAIT == 0) begin
                    ack_q     <= 1'b1;
                    o_DataOut <= rdata;
                end else begin
                    rd_pend <= 1'b1;
                    cnt     <= 4'(RD_WAIT);
                end
            end else if (rd_pend) begin
                cnt <= cnt - 1'b1;
                if (cnt == 4'd1) begin
                    rd_pend   <= 1'b0;
                    ack_q     <= 1'b1;
                    o_DataOut <= rdata;
                end
            end else if (ack_q) begin
                busy <= 1'b0;
            end
        end
    end

endmodule
